// File: rtl/hazard_ctrl_if.sv
// Hazard control bundle: decode/execute fields in, pipeline buffer controls
// and perf/debug status out. The pipeline side is the master, hazard_ctrl
// is the slave.
interface hazard_ctrl_if #(
  parameter int REGBITS = 4,
  parameter int CNTBITS = 16
);
  // Decode/execute fields presented by the decode/execute register
  logic [REGBITS-1:0] src1Index_D;
  logic [REGBITS-1:0] src2Index_D;
  logic               useSrc1_D;
  logic               useSrc2_D;
  logic [REGBITS-1:0] destIndex_E;
  logic               regWrtEn_E;
  logic [1:0]         regFileMux_E;
  logic               noop_E;
  logic [1:0]         pc_sel_E;
  logic               memBusy;

  // Buffer controls
  logic               pcWrtEn;
  logic               fdWrtEn;
  logic               fdFlush;
  logic               deWrtEn;
  logic               deBubble;
  logic               emWrtEn;

  // Perf counters and status
  logic [CNTBITS-1:0] stallCount;
  logic [CNTBITS-1:0] flushCount;
  logic               busy;
  logic [1:0]         state_dbg;

  // Handshake note: there is no valid/ready pairing here. Every input is
  // sampled on each rising clk edge and every control output is valid
  // combinationally within the same cycle; memBusy acts as a global
  // "not ready" that freezes all buffers and all internal state.
  modport master (
    output src1Index_D, src2Index_D, useSrc1_D, useSrc2_D, destIndex_E,
           regWrtEn_E, regFileMux_E, noop_E, pc_sel_E, memBusy,
    input  pcWrtEn, fdWrtEn, fdFlush, deWrtEn, deBubble, emWrtEn,
           stallCount, flushCount, busy, state_dbg
  );

  modport slave (
    input  src1Index_D, src2Index_D, useSrc1_D, useSrc2_D, destIndex_E,
           regWrtEn_E, regFileMux_E, noop_E, pc_sel_E, memBusy,
    output pcWrtEn, fdWrtEn, fdFlush, deWrtEn, deBubble, emWrtEn,
           stallCount, flushCount, busy, state_dbg
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, execute-stage redirect
// flushes, global memory-busy freeze, and saturating perf counters.
module hazard_ctrl #(
  parameter int         REGBITS   = 4,
  parameter logic [1:0] LOAD_SEL  = 2'b01,
  parameter int         LOAD_LAT  = 1,
  parameter int         FLUSH_LAT = 1,
  parameter int         CNTBITS   = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  // The down-counter holds the number of extra cycles still to run after
  // the current one, so it only needs to reach MAXLAT-2.
  localparam int MAXLAT     = (LOAD_LAT > FLUSH_LAT) ? LOAD_LAT : FLUSH_LAT;
  localparam int CW         = (MAXLAT > 2) ? $clog2(MAXLAT - 1) : 1;
  localparam int LOAD_INIT  = (LOAD_LAT > 1) ? LOAD_LAT - 2 : 0;
  localparam int FLUSH_INIT = (FLUSH_LAT > 1) ? FLUSH_LAT - 2 : 0;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CNTBITS-1:0] stall_q, flush_q;
  logic               stall_inc, flush_inc;
  logic               redirect, load_use;
  logic               pc_en, fd_en, fd_flush, de_en, de_bubble, em_en;

  // Hazard detection from the execute-stage fields
  always_comb begin
    redirect = (hz.pc_sel_E != 2'b00) & ~hz.noop_E;
    load_use = ~hz.noop_E & hz.regWrtEn_E & (hz.regFileMux_E == LOAD_SEL) &
               (hz.destIndex_E != '0) &
               ((hz.useSrc1_D & (hz.src1Index_D == hz.destIndex_E)) |
                (hz.useSrc2_D & (hz.src2Index_D == hz.destIndex_E)));
  end

  // Next state and buffer controls; redirect wins in every state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    fd_flush  = 1'b0;
    de_en     = 1'b1;
    de_bubble = 1'b0;
    em_en     = 1'b1;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (reset) begin
      // Outputs stay in the pass-through pattern; the register block resets.
    end else if (hz.memBusy) begin
      pc_en = 1'b0;
      fd_en = 1'b0;
      de_en = 1'b0;
      em_en = 1'b0;
    end else if (redirect) begin
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
      flush_inc = 1'b1;
      if (FLUSH_LAT > 1) begin
        state_d = FLUSH;
        cnt_d   = CW'(FLUSH_INIT);
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (load_use) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_bubble = 1'b1;
            stall_inc = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LU_STALL;
              cnt_d   = CW'(LOAD_INIT);
            end
          end
        end
        LU_STALL: begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          de_bubble = 1'b1;
          stall_inc = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - CW'(1);
        end
        FLUSH: begin
          fd_flush  = 1'b1;
          de_bubble = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - CW'(1);
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State, latency counter and saturating perf counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNTBITS'(1);
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + CNTBITS'(1);
    end
  end

  assign hz.pcWrtEn    = pc_en;
  assign hz.fdWrtEn    = fd_en;
  assign hz.fdFlush    = fd_flush;
  assign hz.deWrtEn    = de_en;
  assign hz.deBubble   = de_bubble;
  assign hz.emWrtEn    = em_en;
  assign hz.stallCount = stall_q;
  assign hz.flushCount = flush_q;
  assign hz.busy       = (state_q != RUN);
  assign hz.state_dbg  = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (short and long latencies, wide and
// narrow counters) share one directed stimulus stream and are checked each
// cycle against a cycles-remaining model plus literal spot checks.
module tb_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [3:0] src1, src2, dest;
  logic       use1, use2, regwr, noop, membusy;
  logic [1:0] mux, pcsel;

  hazard_ctrl_if #(.REGBITS(4), .CNTBITS(16)) if_a ();
  hazard_ctrl_if #(.REGBITS(4), .CNTBITS(3))  if_b ();

  assign if_a.src1Index_D = src1;   assign if_b.src1Index_D = src1;
  assign if_a.src2Index_D = src2;   assign if_b.src2Index_D = src2;
  assign if_a.useSrc1_D   = use1;   assign if_b.useSrc1_D   = use1;
  assign if_a.useSrc2_D   = use2;   assign if_b.useSrc2_D   = use2;
  assign if_a.destIndex_E = dest;   assign if_b.destIndex_E = dest;
  assign if_a.regWrtEn_E  = regwr;  assign if_b.regWrtEn_E  = regwr;
  assign if_a.regFileMux_E = mux;   assign if_b.regFileMux_E = mux;
  assign if_a.noop_E      = noop;   assign if_b.noop_E      = noop;
  assign if_a.pc_sel_E    = pcsel;  assign if_b.pc_sel_E    = pcsel;
  assign if_a.memBusy     = membusy; assign if_b.memBusy    = membusy;

  hazard_ctrl #(.REGBITS(4), .LOAD_SEL(2'b01), .LOAD_LAT(1), .FLUSH_LAT(3),
                .CNTBITS(16)) dut_a (.clk(clk), .reset(reset), .hz(if_a));
  hazard_ctrl #(.REGBITS(4), .LOAD_SEL(2'b01), .LOAD_LAT(3), .FLUSH_LAT(4),
                .CNTBITS(3))  dut_b (.clk(clk), .reset(reset), .hz(if_b));

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: bubble/flush cycles still owed after the current cycle,
  // and event totals clipped at the counter maximum.
  int lat_ld[2] = '{1, 3};
  int lat_fl[2] = '{3, 4};
  int cmax[2]   = '{65535, 7};
  int m_stall[2], m_flush[2], m_sc[2], m_fc[2];

  function automatic logic is_redirect();
    return (pcsel != 2'b00) && !noop;
  endfunction

  function automatic logic is_lu();
    return !noop && regwr && (mux == 2'b01) && (dest != 4'd0) &&
           ((use1 && src1 == dest) || (use2 && src2 == dest));
  endfunction

  // {pcWrtEn, fdWrtEn, fdFlush, deWrtEn, deBubble, emWrtEn, busy}
  function automatic logic [6:0] model_out(input int k);
    logic b;
    b = (m_stall[k] > 0) || (m_flush[k] > 0);
    if (reset)                          return {6'b110101, b};
    if (membusy)                        return {6'b000000, b};
    if (is_redirect() || m_flush[k] > 0) return {6'b111111, b};
    if (m_stall[k] > 0 || is_lu())      return {6'b000111, b};
    return {6'b110101, b};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_stall[k] = 0; m_flush[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end else if (membusy) begin
        // frozen
      end else if (is_redirect()) begin
        if (m_fc[k] < cmax[k]) m_fc[k]++;
        m_flush[k] = lat_fl[k] - 1;
        m_stall[k] = 0;
      end else if (m_flush[k] > 0) begin
        m_flush[k]--;
      end else if (m_stall[k] > 0) begin
        if (m_sc[k] < cmax[k]) m_sc[k]++;
        m_stall[k]--;
      end else if (is_lu()) begin
        if (m_sc[k] < cmax[k]) m_sc[k]++;
        m_stall[k] = lat_ld[k] - 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [6:0]  act_vec[2];
  logic [31:0] act_sc[2], act_fc[2];
  assign act_vec[0] = {if_a.pcWrtEn, if_a.fdWrtEn, if_a.fdFlush, if_a.deWrtEn,
                       if_a.deBubble, if_a.emWrtEn, if_a.busy};
  assign act_vec[1] = {if_b.pcWrtEn, if_b.fdWrtEn, if_b.fdFlush, if_b.deWrtEn,
                       if_b.deBubble, if_b.emWrtEn, if_b.busy};
  assign act_sc[0] = 32'(if_a.stallCount);
  assign act_sc[1] = 32'(if_b.stallCount);
  assign act_fc[0] = 32'(if_a.flushCount);
  assign act_fc[1] = 32'(if_b.flushCount);

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("ctrl_%0d", k), 32'(act_vec[k]), 32'(model_out(k)));
      check($sformatf("stallCount_%0d", k), act_sc[k], 32'(m_sc[k]));
      check($sformatf("flushCount_%0d", k), act_fc[k], 32'(m_fc[k]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    src1 = 4'd0; src2 = 4'd0; dest = 4'd0; use1 = 1'b0; use2 = 1'b0;
    regwr = 1'b0; mux = 2'b00; noop = 1'b0; pcsel = 2'b00; membusy = 1'b0;
  endtask

  task automatic load_r3_use_src1();
    idle();
    regwr = 1'b1; mux = 2'b01; dest = 4'd3; src1 = 4'd3; use1 = 1'b1;
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      end_cycle();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    check("rst_a_pcWrtEn", 32'(if_a.pcWrtEn), 1);
    check("rst_a_fdFlush", 32'(if_a.fdFlush), 0);
    end_cycle();
    reset = 1'b0;

    // Near-miss hazards: no stall
    load_r3_use_src1(); dest = 4'd0; src1 = 4'd0;
    @(negedge clk); check("r0_a_pcWrtEn", 32'(if_a.pcWrtEn), 1); end_cycle();
    load_r3_use_src1(); noop = 1'b1;
    @(negedge clk); check("noop_a_deBubble", 32'(if_a.deBubble), 0); end_cycle();
    load_r3_use_src1(); use1 = 1'b0;
    @(negedge clk); check("nouse_b_fdWrtEn", 32'(if_b.fdWrtEn), 1); end_cycle();
    load_r3_use_src1(); mux = 2'b00;
    @(negedge clk); check("alu_a_pcWrtEn", 32'(if_a.pcWrtEn), 1); end_cycle();
    idle();
    @(negedge clk);
    check("nomiss_a_stall", 32'(if_a.stallCount), 0);
    check("nomiss_b_stall", 32'(if_b.stallCount), 0);
    end_cycle();

    // Load-use on src1
    load_r3_use_src1();
    @(negedge clk);
    check("lu_a_pcWrtEn", 32'(if_a.pcWrtEn), 0);
    check("lu_a_fdWrtEn", 32'(if_a.fdWrtEn), 0);
    check("lu_a_deBubble", 32'(if_a.deBubble), 1);
    end_cycle();
    idle();
    @(negedge clk);
    check("lu_a_after_pc", 32'(if_a.pcWrtEn), 1);
    check("lu_a_count", 32'(if_a.stallCount), 1);
    check("lu_b_busy", 32'(if_b.busy), 1);
    end_cycle();
    cycles(2);
    @(negedge clk); check("lu_b_count", 32'(if_b.stallCount), 3); end_cycle();

    // Load-use on src2
    idle(); regwr = 1'b1; mux = 2'b01; dest = 4'd5; src2 = 4'd5; use2 = 1'b1;
    cycles(1);
    idle(); cycles(3);
    @(negedge clk); check("lu2_a_count", 32'(if_a.stallCount), 2); end_cycle();

    // Redirect: dut_a flushes for 3 cycles, busy for the last 2
    idle(); pcsel = 2'b01;
    @(negedge clk);
    check("rd0_a_fdFlush", 32'(if_a.fdFlush), 1);
    check("rd0_a_busy", 32'(if_a.busy), 0);
    end_cycle();
    idle();
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      check($sformatf("rd%0d_a_fdFlush", i), 32'(if_a.fdFlush), 1);
      check($sformatf("rd%0d_a_busy", i), 32'(if_a.busy), 1);
      end_cycle();
    end
    @(negedge clk);
    check("rd3_a_fdFlush", 32'(if_a.fdFlush), 0);
    check("rd3_a_busy", 32'(if_a.busy), 0);
    check("rd_a_count", 32'(if_a.flushCount), 1);
    end_cycle();
    cycles(2);

    // Redirect and load-use together: flush wins
    load_r3_use_src1(); pcsel = 2'b10;
    @(negedge clk);
    check("rdlu_a_pcWrtEn", 32'(if_a.pcWrtEn), 1);
    check("rdlu_a_fdFlush", 32'(if_a.fdFlush), 1);
    end_cycle();
    idle(); cycles(4);
    @(negedge clk);
    check("rdlu_a_stall", 32'(if_a.stallCount), 2);
    check("rdlu_a_flush", 32'(if_a.flushCount), 2);
    end_cycle();

    // Redirect restarting an ongoing flush; squashed redirect ignored
    idle(); pcsel = 2'b11; cycles(1);
    idle(); cycles(1);
    pcsel = 2'b01; cycles(1);
    idle(); cycles(1);
    @(negedge clk);
    check("rst_fl_a_fdFlush", 32'(if_a.fdFlush), 1);
    check("rst_fl_a_busy", 32'(if_a.busy), 1);
    end_cycle();
    cycles(3);
    pcsel = 2'b01; noop = 1'b1;
    @(negedge clk); check("noop_rd_a_fdFlush", 32'(if_a.fdFlush), 0); end_cycle();
    idle();
    @(negedge clk); check("rd2_a_count", 32'(if_a.flushCount), 4); end_cycle();

    // memBusy freeze in the middle of a 3-cycle stall on dut_b
    reset = 1'b1; cycles(1); reset = 1'b0;
    load_r3_use_src1();
    @(negedge clk);
    check("mb0_b_deBubble", 32'(if_b.deBubble), 1);
    check("mb0_b_pcWrtEn", 32'(if_b.pcWrtEn), 0);
    end_cycle();
    idle(); membusy = 1'b1;
    @(negedge clk);
    check("mb1_b_deWrtEn", 32'(if_b.deWrtEn), 0);
    check("mb1_b_emWrtEn", 32'(if_b.emWrtEn), 0);
    check("mb1_b_deBubble", 32'(if_b.deBubble), 0);
    end_cycle();
    @(negedge clk); check("mb2_b_count", 32'(if_b.stallCount), 1); end_cycle();
    membusy = 1'b0;
    @(negedge clk); check("mb3_b_deBubble", 32'(if_b.deBubble), 1); end_cycle();
    @(negedge clk); check("mb4_b_deBubble", 32'(if_b.deBubble), 1); end_cycle();
    @(negedge clk);
    check("mb5_b_deBubble", 32'(if_b.deBubble), 0);
    check("mb5_b_count", 32'(if_b.stallCount), 3);
    check("mb5_b_busy", 32'(if_b.busy), 0);
    end_cycle();

    // Reset during the second flush cycle of dut_b
    idle(); pcsel = 2'b01; cycles(1);
    idle(); reset = 1'b1;
    @(negedge clk);
    check("rf_b_fdFlush", 32'(if_b.fdFlush), 0);
    check("rf_b_pcWrtEn", 32'(if_b.pcWrtEn), 1);
    check("rf_b_busy", 32'(if_b.busy), 1);
    end_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rf1_b_busy", 32'(if_b.busy), 0);
    check("rf1_b_fdFlush", 32'(if_b.fdFlush), 0);
    check("rf1_b_flush", 32'(if_b.flushCount), 0);
    check("rf1_b_stall", 32'(if_b.stallCount), 0);
    end_cycle();

    // Saturate dut_b's 3-bit stall counter, then one more hazard
    for (int i = 0; i < 3; i++) begin
      load_r3_use_src1(); cycles(1);
      idle(); cycles(3);
    end
    @(negedge clk); check("sat_b_stall", 32'(if_b.stallCount), 7); end_cycle();
    load_r3_use_src1(); cycles(1);
    idle(); cycles(3);
    @(negedge clk);
    check("sat2_b_stall", 32'(if_b.stallCount), 7);
    check("sat2_a_stall", 32'(if_a.stallCount), 4);
    end_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Control-side counterpart of the decode/execute pipeline register: it consumes the execute-stage fields that register presents and produces the write-enable, flush and bubble controls that drive the PC, fetch/decode, decode/execute and execute/memory buffers.
- Detects load-use hazards and execute-stage PC redirects, sequences multi-cycle stalls and flushes with a small FSM, and honours a global memory-busy freeze.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- REGBITS, 4, register index width
- LOAD_SEL, 2'b01, regFileMux_E encoding that marks a load (writeback from memory)
- LOAD_LAT, 1, load-use stall length in cycles (>=1)
- FLUSH_LAT, 1, redirect squash length in cycles (>=1)
- CNTBITS, 16, perf counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- src1Index_D  in  REGBITS  decode-stage source 1 index
- src2Index_D  in  REGBITS  decode-stage source 2 index
- useSrc1_D  in  1  decode instruction reads src1
- useSrc2_D  in  1  decode instruction reads src2
- destIndex_E  in  REGBITS  execute-stage destination index
- regWrtEn_E  in  1  execute instruction writes the register file
- regFileMux_E  in  2  execute writeback select
- noop_E  in  1  execute slot holds a bubble
- pc_sel_E  in  2  execute PC select; nonzero = redirect
- memBusy  in  1  memory stage not ready; freeze the whole pipe
- pcWrtEn  out  1  PC register write enable
- fdWrtEn  out  1  fetch/decode buffer write enable
- fdFlush  out  1  fetch/decode buffer load-as-noop
- deWrtEn  out  1  decode/execute buffer write enable
- deBubble  out  1  force noop_D=1, regWrtEn_D=0, memWrtEn_D=0 into decode/execute
- emWrtEn  out  1  execute/memory buffer write enable
- stallCount  out  CNTBITS  load-use bubble cycles
- flushCount  out  CNTBITS  redirect events
- busy  out  1  FSM not in RUN

Behaviour:
- Reset (clk edge with reset=1): state=RUN, internal counter=0, stallCount=0, flushCount=0. Control outputs are combinational from state and inputs; while reset=1 all write enables are 1 and fdFlush=deBubble=0.
- Signal definitions:
  - redirect = (pc_sel_E!=0) & ~noop_E
  - loadUse = ~noop_E & regWrtEn_E & (regFileMux_E==LOAD_SEL) & destIndex_E!=0 & ((useSrc1_D & src1Index_D==destIndex_E) | (useSrc2_D & src2Index_D==destIndex_E))
- Priority, per cycle:
  - memBusy: all write enables 0, fdFlush=deBubble=0, state, counter and perf counters hold.
  - Otherwise redirect beats loadUse, which beats normal flow.
- FSM states: RUN, LU_STALL, FLUSH.
- RUN, no event: all enables 1, fdFlush=deBubble=0.
- RUN, redirect:
  - pcWrtEn=1 (target loads), fdFlush=1, deBubble=1, deWrtEn=emWrtEn=fdWrtEn=1.
  - flushCount+1.
  - If FLUSH_LAT>1: counter=FLUSH_LAT-2 and go FLUSH.
- RUN, loadUse:
  - pcWrtEn=0, fdWrtEn=0, deWrtEn=1, deBubble=1, emWrtEn=1.
  - stallCount+1.
  - If LOAD_LAT>1: counter=LOAD_LAT-2 and go LU_STALL.
- LU_STALL:
  - Same outputs as the RUN loadUse cycle; stallCount+1 each cycle.
  - Counter==0: go RUN; else counter-1.
  - A redirect here aborts the stall and is handled as in RUN (cannot occur normally, but it is defined).
- FLUSH:
  - pcWrtEn=fdWrtEn=deWrtEn=emWrtEn=1, fdFlush=1, deBubble=1.
  - Counter==0: go RUN; else counter-1.
  - A new redirect restarts the flush (counter reload, flushCount+1). loadUse is ignored.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-flush returns to RUN on that edge; no residual bubble follows.
- busy = (state != RUN).

Test Plan:
- Load r3 in E (regWrtEn_E=1, regFileMux_E=01, destIndex_E=3), D reads src1=3, useSrc1_D=1, LOAD_LAT=1 -> one cycle with pcWrtEn=0, fdWrtEn=0, deBubble=1; next cycle all enables 1; stallCount=1.
- Same hazard with destIndex_E=0, or noop_E=1, or useSrc1_D=0 -> no stall; stallCount stays 0.
- pc_sel_E=2'b01, noop_E=0, FLUSH_LAT=3 -> fdFlush=deBubble=1 for exactly 3 cycles, busy=1 for the last 2; flushCount=1.
- Redirect and loadUse in the same cycle -> flush behaviour only; stallCount unchanged; flushCount+1.
- LOAD_LAT=3 stall with memBusy=1 held 2 cycles in the middle -> all enables 0 during freeze; total bubble cycles still 3; stallCount=3.
- Reset asserted in the second FLUSH cycle (FLUSH_LAT=4) -> next cycle state RUN, fdFlush=0, counters 0; stallCount forced to all-ones stays saturated on a further hazard.
